// File: rtl/fetch_ctrl_if.sv
// Fetch/decode boundary bundle: fetch-side inputs, PC steering outputs and the
// IF/ID register contents exposed to decode.
interface fetch_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [15:0]      instruc;
  logic [15:0]      seq_PC;
  logic             late_rst;
  logic             stall;
  logic             redirect;
  logic [15:0]      redirect_PC;
  logic             en_PC;
  logic             branch;
  logic [15:0]      branch_PC;
  logic [15:0]      id_instr;
  logic [15:0]      id_seq_PC;
  logic             id_valid;
  logic             halted;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output instruc, seq_PC, late_rst, stall, redirect, redirect_PC,
    input  en_PC, branch, branch_PC, id_instr, id_seq_PC, id_valid, halted, flush_cnt
  );

  modport slave (
    input  instruc, seq_PC, late_rst, stall, redirect, redirect_PC,
    output en_PC, branch, branch_PC, id_instr, id_seq_PC, id_valid, halted, flush_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage consumer controller: steers the fetch PC and owns the IF/ID
// register across boot, stalls, EX redirects and HALT drain.
module fetch_ctrl #(
  parameter int          DRAIN_DEPTH = 3,
  parameter logic [15:0] NOP_INSTR   = 16'h0800,
  parameter int          CNT_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.slave  bus
);

  localparam logic [1:0] S_BOOT   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  localparam int             DCW        = (DRAIN_DEPTH > 1) ? $clog2(DRAIN_DEPTH) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_DEPTH - 1);

  logic [1:0]       state_q, state_d;
  logic [15:0]      instr_q, instr_d;
  logic [15:0]      spc_q, spc_d;
  logic             valid_q, valid_d;
  logic [DCW-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             en_pc;
  logic             is_halt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign is_halt = (bus.instruc[15:11] == 5'b00000);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    spc_d   = spc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    en_pc   = 1'b0;
    case (state_q)
      S_BOOT: begin
        if (bus.late_rst) state_d = S_RUN;
      end
      S_RUN: begin
        if (bus.redirect) begin
          en_pc   = 1'b1;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          flush_d = sat_inc(flush_q);
        end else if (!bus.stall) begin
          instr_d = bus.instruc;
          spc_d   = bus.seq_PC;
          valid_d = 1'b1;
          // PC parks on the HALT so fetch keeps presenting it while we drain
          if (is_halt) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            en_pc = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        en_pc = bus.redirect;
        if (bus.redirect) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          flush_d = sat_inc(flush_q);
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (!bus.stall) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (cnt_q == DRAIN_LAST) state_d = S_HALTED;
          else                     cnt_d   = cnt_q + DCW'(1);
        end
      end
      S_HALTED: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      instr_q <= NOP_INSTR;
      spc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      spc_q   <= spc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  assign bus.en_PC     = en_pc;
  assign bus.branch    = bus.redirect & (state_q != S_HALTED);
  assign bus.branch_PC = bus.redirect_PC;
  assign bus.id_instr  = instr_q;
  assign bus.id_seq_PC = spc_q;
  assign bus.id_valid  = valid_q;
  assign bus.halted    = (state_q == S_HALTED);
  assign bus.flush_cnt = flush_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboarded bench for fetch_ctrl: a driver pushes per-cycle expectations
// from a behavioural model, a negedge monitor pops and compares.
module tb_fetch_ctrl;
  localparam int          CNT_W  = 4;
  localparam int          DDEPTH = 3;
  localparam logic [15:0] NOP    = 16'h0800;
  localparam int          FC_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_ctrl_if #(.CNT_W(CNT_W)) bus();

  fetch_ctrl #(.DRAIN_DEPTH(DDEPTH), .NOP_INSTR(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct packed {
    logic             en;
    logic             br;
    logic [15:0]      bpc;
    logic [15:0]      ii;
    logic [15:0]      isp;
    logic             iv;
    logic             h;
    logic [CNT_W-1:0] fc;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase flags plus "drain cycles remaining"
  bit          m_known = 0, m_boot = 1, m_drain = 0, m_halted = 0;
  int          m_left  = 0;
  logic [15:0] m_ii = NOP, m_isp = 16'h0;
  logic        m_iv = 1'b0;
  int          m_fc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("en_PC",     32'(bus.en_PC),     32'(e.en));
      chk("branch",    32'(bus.branch),    32'(e.br));
      chk("branch_PC", 32'(bus.branch_PC), 32'(e.bpc));
      chk("id_instr",  32'(bus.id_instr),  32'(e.ii));
      chk("id_seq_PC", 32'(bus.id_seq_PC), 32'(e.isp));
      chk("id_valid",  32'(bus.id_valid),  32'(e.iv));
      chk("halted",    32'(bus.halted),    32'(e.h));
      chk("flush_cnt", 32'(bus.flush_cnt), 32'(e.fc));
    end
  end

  task automatic bubble();
    m_ii = NOP;
    m_iv = 1'b0;
  endtask

  task automatic flush();
    bubble();
    if (m_fc < FC_MAX) m_fc++;
  endtask

  task automatic step(input bit r, input bit lr, input bit st, input bit rd,
                      input logic [15:0] rpc, input logic [15:0] ins,
                      input logic [15:0] spc);
    exp_t e;
    rst             = r;
    bus.late_rst    = lr;
    bus.stall       = st;
    bus.redirect    = rd;
    bus.redirect_PC = rpc;
    bus.instruc     = ins;
    bus.seq_PC      = spc;
    if (m_known) begin
      e.br  = rd && !m_halted;
      e.bpc = rpc;
      if (m_boot || m_halted) e.en = 1'b0;
      else if (m_drain)       e.en = rd;
      else                    e.en = rd || (!st && ins[15:11] != 5'd0);
      e.ii  = m_ii;
      e.isp = m_isp;
      e.iv  = m_iv;
      e.h   = m_halted;
      e.fc  = CNT_W'(m_fc);
      sbq.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      m_known = 1; m_boot = 1; m_drain = 0; m_halted = 0; m_left = 0;
      m_ii = NOP; m_isp = 16'h0; m_iv = 1'b0; m_fc = 0;
    end else if (m_known) begin
      if (m_boot) begin
        if (lr) m_boot = 0;
      end else if (m_halted) begin
        bubble();
      end else if (m_drain) begin
        if (rd) begin
          flush();
          m_drain = 0;
        end else if (!st) begin
          bubble();
          m_left--;
          if (m_left == 0) begin
            m_drain  = 0;
            m_halted = 1;
          end
        end
      end else begin
        if (rd) flush();
        else if (!st) begin
          m_ii = ins; m_isp = spc; m_iv = 1'b1;
          if (ins[15:11] == 5'd0) begin
            m_drain = 1;
            m_left  = DDEPTH;
          end
        end
      end
    end
    #1;
  endtask

  task automatic run_op(input logic [15:0] ins, input logic [15:0] spc);
    step(0, 1, 0, 0, 16'h0, ins, spc);
  endtask

  initial begin
    logic [15:0] rins;
    bus.late_rst = 0; bus.stall = 0; bus.redirect = 0;
    bus.redirect_PC = '0; bus.instruc = '0; bus.seq_PC = '0;

    // boot window
    step(1, 0, 0, 0, 16'h0, 16'h1234, 16'h0002);
    repeat (3) step(0, 0, 0, 0, 16'h0, 16'h1234, 16'h0002);
    step(0, 1, 0, 0, 16'h0, 16'h1234, 16'h0002);
    run_op(16'h1234, 16'h0002);

    // stall holds, then capture
    repeat (2) step(0, 1, 1, 0, 16'h0, 16'hD2A4, 16'h0012);
    run_op(16'hD2A4, 16'h0012);
    // redirect beats stall
    step(0, 1, 1, 1, 16'h0040, 16'h4444, 16'h0014);
    run_op(16'h3000, 16'h0042);

    // HALT drain with a stall inside, then redirect ignored once halted
    run_op(16'h0000, 16'h0044);
    run_op(16'h0000, 16'h0044);
    step(0, 1, 1, 0, 16'h0, 16'h0000, 16'h0044);
    repeat (2) run_op(16'h0000, 16'h0044);
    step(0, 1, 0, 1, 16'h0080, 16'h0000, 16'h0044);
    step(0, 1, 1, 1, 16'h0090, 16'h0000, 16'h0044);

    // wrong-path HALT cancelled on the 2nd drain cycle
    step(1, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    step(0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
    run_op(16'h07FF, 16'h0010);
    run_op(16'h0000, 16'h0012);
    step(0, 1, 0, 1, 16'h0100, 16'h0000, 16'h0012);
    repeat (4) run_op(16'h5A5A, 16'h0102);

    // saturate flush_cnt, then reset mid-drain
    for (int i = 0; i < FC_MAX + 4; i++) step(0, 1, 0, 1, 16'(i), 16'h6000, 16'h0);
    run_op(16'h0000, 16'h0200);
    run_op(16'h0000, 16'h0200);
    step(1, 1, 1, 1, 16'h0300, 16'h0000, 16'h0200);
    repeat (2) step(0, 0, 0, 0, 16'h0, 16'hABCD, 16'h0002);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rins = 16'($urandom);
      if ($urandom_range(0, 9) == 0) rins[15:11] = 5'd0;
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           16'($urandom), rins, 16'($urandom));
    end

    repeat (3) @(posedge clk);
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
